dbus_arb: RTL and testbench

Two-master arbiter placed in front of the data-bus decoder. It lets the CPU data port (master 0) and a DMA/debug port (master 1) share the single-ported 16-bit data bus that serves RAM (block 0) and GPIO (block 1). It grants one access per cycle using round-robin with bounded locking. It also tracks the one-cycle read latency of the bus so returned data is steered to the master that issued the read.

---
 rtl/dbus_arb.sv | 100 ++++++++++
 tb/tb_dbus_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arb.sv
// Two-master round-robin arbiter with bounded locking for the shared data bus.
// Grants and bus drive are combinational. Read data returns to the issuing master one cycle after its grant.
module dbus_arb #(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_din,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_din,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m_dout,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_din,
    output logic          s_we,
    input  logic [DW-1:0] s_dout
);

    localparam logic [3:0] LockLim = 4'(LOCK_MAX - 1);

    logic       fav_q, fav_d;
    logic       owner_q, owner_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_id;

    logic       any_gnt, g, g_lock, g_we, contested;

    // The last granted master is also the tag of any read still in flight.
    assign rd_id = owner_q;

    always_comb begin
        m0_gnt     = !rst && m0_req && (!m1_req || !fav_q);
        m1_gnt     = !rst && m1_req && (!m0_req || fav_q);
        any_gnt    = m0_gnt || m1_gnt;
        g          = m1_gnt;
        g_lock     = g ? m1_lock : m0_lock;
        g_we       = g ? m1_we : m0_we;
        contested  = m0_req && m1_req;

        fav_d      = fav_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rd_pend_d  = 1'b0;

        s_addr     = '0;
        s_din      = '0;
        s_we       = 1'b0;

        if (any_gnt) begin
            owner_d   = g;
            rd_pend_d = !g_we;
            s_addr    = g ? m1_addr : m0_addr;
            s_din     = g ? m1_din : m0_din;
            s_we      = g_we;
            // A lone locking master keeps favour without spending its budget.
            if (g_lock && !contested) begin
                fav_d = g;
            end else if (g_lock && (lock_cnt_q < LockLim)) begin
                fav_d      = g;
                lock_cnt_d = lock_cnt_q + 4'd1;
            end else begin
                fav_d      = !g;
                lock_cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fav_q      <= 1'b0;
            owner_q    <= 1'b0;
            lock_cnt_q <= 4'd0;
            rd_pend_q  <= 1'b0;
        end else begin
            fav_q      <= fav_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // Gate with rst so a read granted just before reset never returns.
    assign m0_rvalid = !rst && rd_pend_q && !rd_id;
    assign m1_rvalid = !rst && rd_pend_q && rd_id;
    assign m_dout    = s_dout;

endmodule

// File: tb/tb_dbus_arb.sv
// Bench for dbus_arb: directed scenarios with a read-return scoreboard and a simple RAM/GPIO bus model.
module tb_dbus_arb;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_din;
    logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_din;
    logic [DW-1:0] m_dout, s_din, s_dout;
    logic [AW-1:0] s_addr;
    logic          s_we;

    logic [DW-1:0] ram [256];
    logic [DW-1:0] gpio_in = 16'h1234;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] dat;
    } rd_t;
    rd_t sbq[$];

    dbus_arb #(.DW(DW), .AW(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m_dout(m_dout), .s_addr(s_addr), .s_din(s_din), .s_we(s_we),
        .s_dout(s_dout)
    );

    always #5 clk = ~clk;

    // Bus model: block 0 is RAM, block 1 is GPIO input, one-cycle read latency.
    always @(posedge clk) begin
        if (s_we && s_addr[15:13] == 3'd0) ram[s_addr[7:0]] <= s_din;
        if (s_addr[15:13] == 3'd0)      s_dout <= ram[s_addr[7:0]];
        else if (s_addr[15:13] == 3'd1) s_dout <= gpio_in;
        else                            s_dout <= 16'h0000;
    end

    // Read-return monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        rd_t e;
        if (m0_rvalid && m1_rvalid) begin
            checks++;
            failures++;
            $display("FAIL rvalid_both: m0_rvalid=1 m1_rvalid=1, required at most one");
        end else if (m0_rvalid || m1_rvalid) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected: m1_rvalid=%0b m_dout=%h, required no rvalid",
                         m1_rvalid, m_dout);
            end else begin
                e = sbq.pop_front();
                if ({m1_rvalid, m_dout} !== {e.id, e.dat}) begin
                    failures++;
                    $display("FAIL rvalid_data: id=%0b dout=%h, required id=%0b dout=%h",
                             m1_rvalid, m_dout, e.id, e.dat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_din = '0; m0_lock = 0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_din = '0; m1_lock = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        m0_req = 1; m0_we = 1; m0_addr = 16'h0010;
        m1_req = 1; m1_we = 1; m1_addr = 16'h2000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt, s_we, m0_rvalid, m1_rvalid} !== 5'b0) begin
                failures++;
                $display("FAIL reset_hold: gnt=%b%b s_we=%b rvalid=%b%b, required all 0",
                         m0_gnt, m1_gnt, s_we, m0_rvalid, m1_rvalid);
            end
            step();
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_gnt: gnt0=%b gnt1=%b, required 1 0", m0_gnt, m1_gnt);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_round_robin();
        logic exp_g;
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_din = 16'h1111;
        m1_req = 1; m1_we = 1; m1_addr = 16'h2000; m1_din = 16'h2222;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2) == 1;
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt, s_we, s_addr, s_din} !==
                {!exp_g, exp_g, 1'b1, exp_g ? 16'h2000 : 16'h0010, exp_g ? 16'h2222 : 16'h1111}) begin
                failures++;
                $display("FAIL rr_cycle%0d: gnt=%b%b s_addr=%h s_din=%h, required master %0d",
                         i, m0_gnt, m1_gnt, s_addr, s_din, exp_g);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_read_steer();
        do_reset();
        m1_req = 1; m1_we = 0; m1_addr = 16'h0005;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, s_addr} !== {2'b01, 16'h0005}) begin
            failures++;
            $display("FAIL steer_m1_gnt: gnt=%b%b s_addr=%h, required 01 0005", m0_gnt, m1_gnt, s_addr);
        end
        sbq.push_back('{id: 1'b1, dat: 16'hBEEF});
        step();
        idle();
        m0_req = 1; m0_we = 0; m0_addr = 16'h2000;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL steer_m0_gnt: gnt=%b%b, required 10", m0_gnt, m1_gnt);
        end
        sbq.push_back('{id: 1'b0, dat: 16'h1234});
        step();
        idle();
        step();
        step();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL steer_drain: %0d reads outstanding, required 0", sbq.size());
        end
    endtask

    task automatic test_lock_bound();
        logic [10:0] exp_seq;
        exp_seq = 11'b01111011110;
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 16'h0010;
        m1_req = 1; m1_we = 1; m1_addr = 16'h0011; m1_lock = 1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== {!exp_seq[10-i], exp_seq[10-i]}) begin
                failures++;
                $display("FAIL lock_cycle%0d: gnt=%b%b, required master %0d",
                         i, m0_gnt, m1_gnt, exp_seq[10-i]);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_lone();
        logic [4:0] exp_seq;
        exp_seq = 5'b00001;
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 16'h0012; m0_lock = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== 2'b10) begin
                failures++;
                $display("FAIL lone_cycle%0d: gnt=%b%b, required 10", i, m0_gnt, m1_gnt);
            end
            step();
        end
        m1_req = 1; m1_we = 1; m1_addr = 16'h0013;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== {!exp_seq[4-i], exp_seq[4-i]}) begin
                failures++;
                $display("FAIL lone_contest%0d: gnt=%b%b, required master %0d",
                         i, m0_gnt, m1_gnt, exp_seq[4-i]);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 16'h0005;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL midrd_gnt: gnt=%b%b, required 10", m0_gnt, m1_gnt);
        end
        step();
        idle();
        rst = 1;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt} !== 4'b0) begin
            failures++;
            $display("FAIL midrd_rvalid: rvalid=%b%b gnt=%b%b, required 0000",
                     m0_rvalid, m1_rvalid, m0_gnt, m1_gnt);
        end
        step();
        rst = 0;
        m0_req = 1; m0_we = 1; m0_addr = 16'h0014;
        m1_req = 1; m1_we = 1; m1_addr = 16'h0015;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b1000) begin
            failures++;
            $display("FAIL midrd_after: gnt=%b%b rvalid=%b%b, required gnt 10 rvalid 00",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 16'h0020; m0_din = 16'hA5A5;
        step();
        m0_we = 0; m0_din = '0;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0005;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_first: gnt=%b%b, required 01", m0_gnt, m1_gnt);
        end
        sbq.push_back('{id: 1'b1, dat: 16'hBEEF});
        step();
        m1_req = 0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_second: gnt=%b%b, required 10", m0_gnt, m1_gnt);
        end
        sbq.push_back('{id: 1'b0, dat: 16'hA5A5});
        step();
        idle();
        step();
        step();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain: %0d reads outstanding, required 0", sbq.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[5] = 16'hBEEF;
        idle();
        rst = 1;
        #1;
        test_reset();
        test_round_robin();
        test_read_steer();
        test_lock_bound();
        test_lone();
        test_reset_mid_read();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
